// File: rtl/sram_port_arbiter.sv
// Shares one sram-like slave port between instruction fetch and MEM-stage data.
// Optional perf counters are built only when ARB_PERF_CNT_EN is defined.
module sram_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              sram_req,
  output logic              sram_wr,
  output logic [1:0]        sram_size,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic              sram_addr_ok,
  input  logic              sram_data_ok,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]       perf_inst_cnt,
  output logic [31:0]       perf_data_cnt,
  output logic [31:0]       perf_stall_cnt,
`endif
  input  logic [DATA_W-1:0] sram_rdata
);

  typedef struct packed {
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, WAIT_DATA = 2'd2} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state, state_nxt;
  logic       owner_d;      // 1: data owns the locked/in-flight transaction
  logic [3:0] starve_cnt;
  req_t       inst_pl, data_pl, fwd_pl;
  logic       any_req, win_data, sel_data, granting, accept, resp;

  assign inst_pl = '{wr: inst_wr, size: inst_size, addr: inst_addr, wdata: inst_wdata};
  assign data_pl = '{wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata};

  // Fresh decision only in IDLE; afterwards the latched owner steers everything.
  always_comb begin
    any_req  = inst_req | data_req;
    win_data = data_req & ~(inst_req & (starve_cnt == LIMIT));
    sel_data = (state == IDLE) ? win_data : owner_d;
    granting = ((state == IDLE) & any_req) | (state == HOLD);
    accept   = granting & sram_addr_ok;
    resp     = (state == WAIT_DATA) & sram_data_ok;
    fwd_pl   = sel_data ? data_pl : inst_pl;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (any_req) state_nxt = sram_addr_ok ? WAIT_DATA : HOLD;
      HOLD:      if (sram_addr_ok) state_nxt = WAIT_DATA;
      WAIT_DATA: if (sram_data_ok) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_d    <= 1'b0;
      starve_cnt <= '0;
    end else begin
      if (state == IDLE && any_req) owner_d <= win_data;
      if (accept) begin
        if (!sel_data)
          starve_cnt <= '0;
        else if (inst_req && starve_cnt != LIMIT)
          starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  // Every output is held at zero while reset is asserted, forwarded path included.
  always_comb begin
    sram_req     = 1'b0;
    sram_wr      = 1'b0;
    sram_size    = '0;
    sram_addr    = '0;
    sram_wdata   = '0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    inst_rdata   = '0;
    data_rdata   = '0;
    if (rst) begin
      if (granting) begin
        sram_req   = 1'b1;
        sram_wr    = fwd_pl.wr;
        sram_size  = fwd_pl.size;
        sram_addr  = fwd_pl.addr;
        sram_wdata = fwd_pl.wdata;
      end
      inst_addr_ok = accept & ~sel_data;
      data_addr_ok = accept & sel_data;
      inst_data_ok = resp & ~owner_d;
      data_data_ok = resp & owner_d;
      if (resp & ~owner_d) inst_rdata = sram_rdata;
      if (resp & owner_d)  data_rdata = sram_rdata;
    end
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_inst_cnt  <= '0;
      perf_data_cnt  <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (accept & ~sel_data) perf_inst_cnt  <= perf_inst_cnt + 32'd1;
      if (accept & sel_data)  perf_data_cnt  <= perf_data_cnt + 32'd1;
      if (any_req & ~accept)  perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed + randomized bench for sram_port_arbiter against a transaction-level model.
module tb_sram_port_arbiter;
  localparam int LIMIT = 2;

  logic        clk = 1'b0, rst = 1'b0;
  logic        inst_req = 1'b0, inst_wr = 1'b0, data_req = 1'b0, data_wr = 1'b0;
  logic [1:0]  inst_size = '0, data_size = '0;
  logic [31:0] inst_addr = '0, inst_wdata = '0, data_addr = '0, data_wdata = '0;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        sram_req, sram_wr;
  logic [1:0]  sram_size;
  logic [31:0] sram_addr, sram_wdata;
  logic        sram_addr_ok = 1'b0, sram_data_ok = 1'b0;
  logic [31:0] sram_rdata = '0;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_inst_cnt, perf_data_cnt, perf_stall_cnt;
  int          stall_exp;
`endif

  int vectors = 0, miscompares = 0;
  bit inst_p, data_p;          // model: requester currently pending
  int streak, cnt_i, cnt_d;    // model: consecutive data wins over pending inst, accept counts

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok),
`ifdef ARB_PERF_CNT_EN
    .perf_inst_cnt(perf_inst_cnt), .perf_data_cnt(perf_data_cnt),
    .perf_stall_cnt(perf_stall_cnt),
`endif
    .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

`ifdef ARB_PERF_CNT_EN
  always @(posedge clk or negedge rst)
    if (!rst) stall_exp <= 0;
    else if ((inst_req || data_req) && !sram_addr_ok) stall_exp <= stall_exp + 1;
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic raise_inst();
    inst_p = 1'b1; inst_req = 1'b1;
    inst_addr = $urandom; inst_wdata = $urandom;
    inst_wr = 1'($urandom_range(0, 1)); inst_size = 2'($urandom_range(0, 2));
  endtask

  task automatic raise_data();
    data_p = 1'b1; data_req = 1'b1;
    data_addr = $urandom; data_wdata = $urandom;
    data_wr = 1'($urandom_range(0, 1)); data_size = 2'($urandom_range(0, 2));
  endtask

  task automatic model_clear();
    inst_p = 1'b0; data_p = 1'b0; streak = 0; cnt_i = 0; cnt_d = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    inst_req = 1'b1; data_req = 1'b1; sram_addr_ok = 1'b1; sram_data_ok = 1'b1;
    sram_rdata = 32'hFFFF_FFFF; inst_addr = $urandom; data_addr = $urandom;
    #1;
    chk("rst_sram_req", 32'(sram_req), 32'd0);
    chk("rst_sram_addr", sram_addr, 32'd0);
    chk("rst_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
    chk("rst_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    chk("rst_rdata", inst_rdata | data_rdata, 32'd0);
    cyc();
    inst_req = 1'b0; data_req = 1'b0; sram_addr_ok = 1'b0; sram_data_ok = 1'b0;
    sram_rdata = '0;
    model_clear();
    rst = 1'b1;
    #1;
    chk("idle_sram_req", 32'(sram_req), 32'd0);
    cyc();
  endtask

  // One arbitration round: grant, optional HOLD cycles, acceptance, response.
  task automatic round(input bit new_i, input bit new_d, input int dly_a, input int dly_d,
                       input bit raise_other, input bit stray, input logic [31:0] rd);
    bit          win_d;
    logic [31:0] ea, ew;
    logic        ewr;
    logic [1:0]  esz;
    if (new_i && !inst_p) raise_inst();
    if (new_d && !data_p) raise_data();
    win_d = data_p && !(inst_p && streak == LIMIT);
    ea  = win_d ? data_addr  : inst_addr;
    ew  = win_d ? data_wdata : inst_wdata;
    ewr = win_d ? data_wr    : inst_wr;
    esz = win_d ? data_size  : inst_size;
    for (int k = 0; k < dly_a; k++) begin
      if (k == 1 && raise_other) begin
        if (win_d && !inst_p) raise_inst();
        else if (!win_d && !data_p) raise_data();
      end
      sram_data_ok = stray && (k == 0);
      sram_rdata = $urandom;
      #1;
      chk("hold_req", 32'(sram_req), 32'd1);
      chk("hold_addr", sram_addr, ea);
      chk("hold_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
      chk("stray_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
      assert (win_d ? data_req : inst_req)
        else $error("protocol: granted requester dropped req before acceptance");
      cyc();
    end
    sram_data_ok = 1'b0; sram_addr_ok = 1'b1;
    #1;
    chk("acc_req", 32'(sram_req), 32'd1);
    chk("acc_addr", sram_addr, ea);
    chk("acc_wdata", sram_wdata, ew);
    chk("acc_wr", 32'(sram_wr), 32'(ewr));
    chk("acc_size", 32'(sram_size), 32'(esz));
    chk("acc_inst_addr_ok", 32'(inst_addr_ok), 32'(!win_d));
    chk("acc_data_addr_ok", 32'(data_addr_ok), 32'(win_d));
    if (win_d) begin
      cnt_d++;
      if (inst_p && streak < LIMIT) streak++;
    end else begin
      cnt_i++;
      streak = 0;
    end
    cyc();
    sram_addr_ok = 1'b0;
    if (win_d) begin data_p = 1'b0; data_req = 1'b0; end
    else       begin inst_p = 1'b0; inst_req = 1'b0; end
    for (int k = 0; k < dly_d; k++) begin
      #1;
      chk("wait_req", 32'(sram_req), 32'd0);
      chk("wait_ok", 32'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 32'd0);
      cyc();
    end
    sram_data_ok = 1'b1; sram_rdata = rd;
    #1;
    chk("rsp_req", 32'(sram_req), 32'd0);
    chk("rsp_inst_data_ok", 32'(inst_data_ok), 32'(!win_d));
    chk("rsp_data_data_ok", 32'(data_data_ok), 32'(win_d));
    chk("rsp_inst_rdata", inst_rdata, win_d ? 32'd0 : rd);
    chk("rsp_data_rdata", data_rdata, win_d ? rd : 32'd0);
    cyc();
    sram_data_ok = 1'b0;
  endtask

  initial begin
    bit ni, nd;
    model_clear();
    do_reset();

    // inst read only
    inst_p = 1'b1; inst_req = 1'b1; inst_addr = 32'hBFC0_0000; inst_wr = 1'b0; inst_size = 2'd2;
    round(1'b0, 1'b0, 0, 1, 1'b0, 1'b0, 32'h3C08_BFAF);

    // simultaneous requests: data first, then inst
    do_reset();
    round(1'b1, 1'b1, 0, 0, 1'b0, 1'b0, $urandom);
    round(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, $urandom);

    // grant lock: inst held in HOLD while data arrives
    do_reset();
    round(1'b1, 1'b0, 3, 1, 1'b1, 1'b1, $urandom);
    round(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, $urandom);

    // starvation: data keeps requesting alongside inst
    do_reset();
    for (int r = 0; r < 4; r++) round(1'b1, 1'b1, 0, 0, 1'b0, 1'b0, $urandom);

    // reset while a response is outstanding
    do_reset();
    raise_data();
    sram_addr_ok = 1'b1;
    #1;
    chk("mid_addr_ok", 32'(data_addr_ok), 32'd1);
    cyc();
    data_req = 1'b0; sram_addr_ok = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_req", 32'(sram_req), 32'd0);
    cyc();
    model_clear();
    rst = 1'b1; sram_data_ok = 1'b1; sram_rdata = 32'hDEAD_BEEF;
    #1;
    chk("mid_stray_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    chk("mid_stray_rdata", inst_rdata | data_rdata, 32'd0);
    cyc();
    sram_data_ok = 1'b0;
    round(1'b1, 1'b0, 1, 0, 1'b0, 1'b0, $urandom);

    // randomized traffic
    for (int r = 0; r < 60; r++) begin
      ni = 1'($urandom_range(0, 1));
      nd = 1'($urandom_range(0, 1));
      if (!(inst_p || data_p || ni || nd)) nd = 1'b1;
      round(ni, nd, $urandom_range(0, 3), $urandom_range(0, 2),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
    end

`ifdef ARB_PERF_CNT_EN
    #1;
    chk("perf_inst_cnt", perf_inst_cnt, 32'(cnt_i));
    chk("perf_data_cnt", perf_data_cnt, 32'(cnt_d));
    chk("perf_stall_cnt", perf_stall_cnt, 32'(stall_exp));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one sram-like memory port between the instruction-fetch requester (inst_*) and the MEM-stage data requester (data_*), in front of the sram-to-AXI bridge.
- Arbitrates requests and locks the grant until the slave accepts the address.
- Tracks the single in-flight transaction and routes the slave's response back to its owner only.
- Data has fixed priority, with starvation protection for instruction fetch.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, read/write data width.
- STARVE_LIMIT, 4, consecutive data wins while inst_req is pending before inst is forced to win; legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- inst_req / inst_wr  in  1/1  instruction request / write flag.
- inst_size  in  2  transfer size (0 byte, 1 half, 2 word).
- inst_addr / inst_wdata  in  ADDR_W/DATA_W  address / write data.
- inst_addr_ok / inst_data_ok  out  1/1  address accepted / response valid.
- inst_rdata  out  DATA_W  read data.
- data_req, data_wr, data_size, data_addr, data_wdata  in  as inst_*  data requester.
- data_addr_ok, data_data_ok, data_rdata  out  as inst_*  data responses.
- sram_req, sram_wr, sram_size, sram_addr, sram_wdata  out  1/1/2/ADDR_W/DATA_W  to slave.
- sram_addr_ok, sram_data_ok  in  1/1  slave handshakes.
- sram_rdata  in  DATA_W  slave read data.

Behaviour:
- Protocol: request accepted when req and addr_ok are both high. The requester holds req and payload stable until accepted. The response is a one-cycle data_ok with rdata. At most one transaction is outstanding.
- FSM states IDLE, HOLD, WAIT_DATA; reset state IDLE. starve_cnt (4 bits) resets to 0.
- IDLE grant decision (combinational):
  - If inst_req and starve_cnt==STARVE_LIMIT, inst wins.
  - Else if data_req, data wins.
  - Else if inst_req, inst wins.
  - Else no grant.
  - The winner's payload drives sram_* and sram_req=1 in the same cycle (zero-cycle forwarding).
- IDLE transitions:
  - sram_addr_ok high: pulse the winner's *_addr_ok combinationally, register owner, go to WAIT_DATA.
  - sram_addr_ok low: register grant, go to HOLD.
- HOLD: the grant is locked. sram_* follows the locked requester even if the other raises req. Go to WAIT_DATA on sram_addr_ok, pulsing the owner's addr_ok.
- WAIT_DATA: sram_req=0. On sram_data_ok, drive owner_data_ok=1 and owner_rdata=sram_rdata combinationally, then go to IDLE next cycle. There is one idle bubble cycle before the next grant.
- The non-owner's addr_ok and data_ok are always 0. inst_rdata and data_rdata are 0 when not valid.
- starve_cnt update, once per acceptance:
  - Increment (saturating at STARVE_LIMIT) when data is accepted while inst_req is high.
  - Clear when inst is accepted.
  - Hold otherwise.
- sram_data_ok in IDLE or HOLD is stray: ignored, not routed, no state change.
- Reset (rst low, asynchronous):
  - FSM goes to IDLE, owner is cleared, starve_cnt=0.
  - All outputs are forced to 0 while rst is low, including forwarded sram_*.
  - An in-flight response is dropped; its later data_ok is treated as stray.
- If the requester drops req in HOLD, this is a protocol violation. The arbiter keeps forwarding the latched selection, and the bench flags it with an assertion.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- When defined, adds outputs perf_inst_cnt[31:0] and perf_data_cnt[31:0]. Each counts accepted transactions for its requester, wraps at 2^32, and resets to 0.
- Also adds perf_stall_cnt[31:0], which counts cycles any requester has req high without acceptance.
- When undefined, none of these ports or registers exist.

Test Plan:
- Inst read only:
  - Stimulus: inst_addr=0xBFC00000; sram_addr_ok high in cycle 0; sram_data_ok at cycle 2 with 0x3C08BFAF.
  - Response: inst_addr_ok in cycle 0; inst_data_ok with inst_rdata=0x3C08BFAF in cycle 2; data_* outputs stay 0.
- Simultaneous requests:
  - Stimulus: inst and data req in the same cycle, slave accepts immediately.
  - Response: data is granted first; inst is granted in the cycle after the data response bubble; sram_addr matches each requester in turn.
- Grant lock:
  - Stimulus: inst granted, sram_addr_ok delayed 3 cycles, data_req rises in HOLD.
  - Response: sram_addr stays at inst_addr until acceptance; data is served afterwards.
- Starvation:
  - Stimulus: STARVE_LIMIT=2; data_req held continuously; inst_req held.
  - Response: data wins twice, inst wins the 3rd arbitration, then starve_cnt=0.
- Reset mid-transaction:
  - Stimulus: rst low during WAIT_DATA; release; slave then pulses sram_data_ok=1 with 0xDEADBEEF.
  - Response: both data_ok outputs stay 0; the next request is arbitrated normally.
- ARB_PERF_CNT_EN defined:
  - Stimulus: 3 data and 2 inst transactions.
  - Response: perf_data_cnt=3, perf_inst_cnt=2; perf_stall_cnt equals the scripted wait cycles.
